adc_to_sdram: RTL and testbench
===============================

# adc_to_sdram

Capture path from the 8-bit ADC into SDRAM, the write-side counterpart of the SDRAM-to-DAC playback path. Generates the ADC conversion clock, samples at a fixed divided rate, and buffers samples in a small internal FIFO. Issues fixed-length write bursts to the SDRAM controller's write port, with a wrapping address counter over a circular buffer region.

## Interface
- CLK_DIV, 4: ADC sample period in clk cycles; legal range 2..256.
- FIFO_DEPTH, 16: internal sample FIFO depth; power of 2, at least 2*BURST_LEN.
- BURST_LEN, 8: words per SDRAM write burst; power of 2.
- ADDR_W, 24: SDRAM word address width.
- BASE_ADDR, 0: first address of the circular capture region.
- END_ADDR, 1024: exclusive end of the region; (END_ADDR-BASE_ADDR) is a multiple of BURST_LEN.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  capture enable; sampling runs only while high.
- adc_data  in  8  ADC conversion result.
- adc_clk  out  1  ADC conversion clock.
- sdram_wr_req  out  1  burst write request.
- sdram_wr_grant  in  1  one-cycle grant from the SDRAM controller.
- sdram_wr_addr  out  ADDR_W  burst start address; stable while sdram_wr_req is high.
- sdram_wr_en  out  1  write data strobe, one per word.
- sdram_wr_data  out  8  write data, valid when sdram_wr_en is high.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.

## Operation
- Reset values: adc_clk 0, sdram_wr_req 0, sdram_wr_en 0, sdram_wr_data 0, sdram_wr_addr BASE_ADDR, fifo_level 0, overflow 0; FSM in IDLE; divider 0.
- Divider counts 0..CLK_DIV-1 while enable is high.
  - adc_clk is high for counts < CLK_DIV/2, low otherwise.
  - The sample is taken on the edge where the count is CLK_DIV-1.
- When enable is low, the divider is held at 0, adc_clk is low, and no samples are pushed.
- Sample push: adc_data is written to the FIFO tail.
  - If the FIFO is full, the sample is dropped and overflow is set.
  - overflow clears only on reset.
- FSM states and transitions:
  - IDLE → REQ when fifo_level >= BURST_LEN.
  - REQ: sdram_wr_req is high; → BURST on sdram_wr_grant.
  - BURST: sdram_wr_en is high for exactly BURST_LEN consecutive cycles, popping one word per cycle onto sdram_wr_data; → IDLE after the last beat.
- Address update: after the last beat, sdram_wr_addr += BURST_LEN. If the result equals END_ADDR, it wraps to BASE_ADDR.
- Simultaneous push and pop in one cycle: both take effect and fifo_level is unchanged.
- No underflow is possible: BURST entry requires at least BURST_LEN words, and pushes are never blocked by pops.
- Deasserting enable mid-burst does not abort the burst.
  - An outstanding REQ stays pending until granted.
  - Residual words below BURST_LEN remain in the FIFO until capture resumes.
- sdram_wr_grant outside REQ is ignored.
- Reset mid-burst: all state returns immediately to reset values, the FIFO is emptied, and no further sdram_wr_en is issued.

## Timing
- Sample edge at cycle S: fifo_level reflects the push from S+1.
- IDLE sees fifo_level >= BURST_LEN in cycle N: sdram_wr_req is high from N+1.
- Grant sampled high in cycle G:
  - sdram_wr_req is low from G+1.
  - sdram_wr_en is high in cycles G+1..G+BURST_LEN, with FIFO-order data registered with the strobe.
  - FSM is in IDLE at G+BURST_LEN+1.
  - sdram_wr_addr holds its new value from G+BURST_LEN+1.
- The earliest next request is G+BURST_LEN+2.
- Grant latency is unbounded. With CLK_DIV=4 and the default depth, samples are dropped once the grant is delayed enough for the FIFO to reach 16.

## Test plan
- Reset, enable=1, ramp adc_data 0,1,2,… changing every 4 cycles, grant 2 cycles after each request → bursts at addresses 0,8,16 carrying 0..7, 8..15, 16..23; no gaps; overflow stays 0.
- END_ADDR=32, continuous capture → the fifth burst goes to address 0 (wrap) and carries samples 32..39.
- Grant withheld for 100 cycles → fifo_level saturates at 16 and overflow is set. After the grant, the first burst contains the oldest 8 samples in order, and overflow stays 1.
- enable drops after 12 samples, grant given → one burst of 8 words is written, fifo_level ends at 4, and adc_clk stays low.
- Assert rst_n low during beat 3 of a burst → sdram_wr_en is low immediately, fifo_level is 0, sdram_wr_addr is BASE_ADDR, and overflow is 0.
- Grant pulse while in IDLE with fifo_level 3 → no sdram_wr_en, and state is unchanged.

Source files
------------

// File: rtl/adc_to_sdram.sv
// ADC capture path: divided-rate sampling into a small FIFO, drained to SDRAM
// in fixed-length write bursts over a wrapping circular address region.
module adc_to_sdram #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned END_ADDR   = 1024
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic [7:0]                          adc_data,
    output logic                                adc_clk,
    output logic                                sdram_wr_req,
    input  logic                                sdram_wr_grant,
    output logic [ADDR_W-1:0]                   sdram_wr_addr,
    output logic                                sdram_wr_en,
    output logic [7:0]                          sdram_wr_data,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
    output logic                                overflow
);

    localparam int unsigned DIV_W  = $clog2(CLK_DIV);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned HALF   = CLK_DIV / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic [DIV_W-1:0]    div_nxt;
    logic                sample;
    logic                push;
    logic                drop;
    logic                pop_c;
    logic                last_c;
    logic                req_d;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [7:0]          mem [FIFO_DEPTH];

    // Sample divider: the count that will hold next cycle also drives adc_clk
    always_comb begin
        sample  = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
        div_nxt = '0;
        if (enable && !sample) begin
            div_nxt = div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            adc_clk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            adc_clk <= enable && (div_nxt < DIV_W'(HALF));
        end
    end

    // Full check uses the pre-pop level, so a sample arriving on a pop edge of a full FIFO is dropped
    always_comb begin
        push = sample && (fifo_level != LVL_W'(FIFO_DEPTH));
        drop = sample && (fifo_level == LVL_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= adc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            case ({push, pop_c})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fifo_level >= LVL_W'(BURST_LEN)) state_nxt = REQ;
            REQ:     if (sdram_wr_grant) state_nxt = BURST;
            BURST:   if (beat_cnt == BEAT_W'(BURST_LEN - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A word is popped on every edge that leads into a BURST cycle, so data lands with its strobe
    always_comb begin
        pop_c  = 1'b0;
        last_c = 1'b0;
        req_d  = 1'b0;
        case (state_nxt)
            REQ:     req_d = 1'b1;
            BURST:   pop_c = 1'b1;
            default: ;
        endcase
        if (state == BURST && beat_cnt == BEAT_W'(BURST_LEN - 1)) begin
            last_c = 1'b1;
        end
    end

    always_comb begin
        addr_nxt = sdram_wr_addr + ADDR_W'(BURST_LEN);
        if (addr_nxt == ADDR_W'(END_ADDR)) begin
            addr_nxt = ADDR_W'(BASE_ADDR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdram_wr_req  <= 1'b0;
            sdram_wr_en   <= 1'b0;
            sdram_wr_data <= '0;
            sdram_wr_addr <= ADDR_W'(BASE_ADDR);
            beat_cnt      <= '0;
        end else begin
            sdram_wr_req <= req_d;
            sdram_wr_en  <= pop_c;
            if (pop_c) begin
                sdram_wr_data <= mem[rd_ptr];
            end
            if (last_c) begin
                sdram_wr_addr <= addr_nxt;
            end
            if (state == BURST) begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end else begin
                beat_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adc_to_sdram.sv
// Scoreboard bench for adc_to_sdram: a sampling model pushes expected words,
// burst beats pop and compare them.
module tb_adc_to_sdram;

    localparam int BL    = 8;
    localparam int DEPTH = 16;
    localparam int CDIV  = 4;
    localparam int END_A = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  adc_data;
    logic        adc_clk;
    logic        sdram_wr_req;
    logic        sdram_wr_grant;
    logic [23:0] sdram_wr_addr;
    logic        sdram_wr_en;
    logic [7:0]  sdram_wr_data;
    logic [4:0]  fifo_level;
    logic        overflow;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  sb[$];
    int          mdl_cnt = 0;
    int          smp_idx = 0;
    int          exp_addr = 0;

    adc_to_sdram #(
        .CLK_DIV(CDIV), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL),
        .ADDR_W(24), .BASE_ADDR(0), .END_ADDR(END_A)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .adc_data(adc_data),
        .adc_clk(adc_clk), .sdram_wr_req(sdram_wr_req),
        .sdram_wr_grant(sdram_wr_grant), .sdram_wr_addr(sdram_wr_addr),
        .sdram_wr_en(sdram_wr_en), .sdram_wr_data(sdram_wr_data),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    always #10 clk = ~clk;

    // Sampling model: divider plus bounded FIFO occupancy; feeds the scoreboard
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                sb.delete();
                mdl_cnt = 0;
                smp_idx = 0;
            end else if (enable) begin
                if (mdl_cnt == CDIV - 1) begin
                    if (sb.size() < DEPTH) sb.push_back(adc_data);
                    smp_idx = smp_idx + 1;
                    mdl_cnt = 0;
                end else begin
                    mdl_cnt = mdl_cnt + 1;
                end
            end else begin
                mdl_cnt = 0;
            end
        end
    end

    // Ramp source: each sample slot carries its own index
    initial begin
        forever begin
            @(negedge clk);
            adc_data = 8'(smp_idx);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        sdram_wr_grant = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_addr = 0;
    endtask

    task automatic wait_samples(input int n, input string tag);
        int t;
        t = 0;
        while (smp_idx < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (smp_idx < n) begin
            bad++;
            $display("FAIL %s_sample_wait: got %0d samples required %0d", tag, smp_idx, n);
        end
    endtask

    task automatic serve_burst(input int delay, input int first, input string tag);
        int t;
        logic [7:0] e;
        t = 0;
        while (sdram_wr_req !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (sdram_wr_req !== 1'b1) begin
            bad++;
            $display("FAIL %s_req_timeout: req=%b required 1", tag, sdram_wr_req);
            return;
        end
        total++;
        if (fifo_level < 5'(BL)) begin
            bad++;
            $display("FAIL %s_req_level: level=%0d required >=%0d", tag, fifo_level, BL);
        end
        total++;
        if (sdram_wr_addr !== 24'(exp_addr)) begin
            bad++;
            $display("FAIL %s_req_addr: addr=%0d required %0d", tag, sdram_wr_addr, exp_addr);
        end
        repeat (delay) @(negedge clk);
        sdram_wr_grant = 1'b1;
        @(negedge clk);
        sdram_wr_grant = 1'b0;
        total++;
        if (sdram_wr_req !== 1'b0) begin
            bad++;
            $display("FAIL %s_req_drop: req=%b required 0", tag, sdram_wr_req);
        end
        for (int b = 0; b < BL; b++) begin
            if (b > 0) @(negedge clk);
            total++;
            if (sdram_wr_en !== 1'b1) begin
                bad++;
                $display("FAIL %s_beat%0d_en: en=%b required 1", tag, b, sdram_wr_en);
            end
            e = 8'hxx;
            if (sb.size() > 0) e = sb.pop_front();
            total++;
            if (sdram_wr_data !== e) begin
                bad++;
                $display("FAIL %s_beat%0d_data: data=%0d required %0d", tag, b, sdram_wr_data, e);
            end
            if (first >= 0) begin
                total++;
                if (sdram_wr_data !== 8'(first + b)) begin
                    bad++;
                    $display("FAIL %s_beat%0d_ramp: data=%0d required %0d", tag, b, sdram_wr_data, first + b);
                end
            end
        end
        @(negedge clk);
        total++;
        if (sdram_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL %s_burst_len: en=%b after last beat required 0", tag, sdram_wr_en);
        end
        exp_addr = exp_addr + BL;
        if (exp_addr == END_A) exp_addr = 0;
        total++;
        if (sdram_wr_addr !== 24'(exp_addr)) begin
            bad++;
            $display("FAIL %s_addr_update: addr=%0d required %0d", tag, sdram_wr_addr, exp_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        sdram_wr_grant = 1'b0;
        repeat (2) @(negedge clk);
        total += 7;
        if (adc_clk !== 1'b0) begin bad++; $display("FAIL rst_adc_clk: got %b required 0", adc_clk); end
        if (sdram_wr_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b required 0", sdram_wr_req); end
        if (sdram_wr_en !== 1'b0) begin bad++; $display("FAIL rst_en: got %b required 0", sdram_wr_en); end
        if (sdram_wr_data !== 8'd0) begin bad++; $display("FAIL rst_data: got %0d required 0", sdram_wr_data); end
        if (sdram_wr_addr !== 24'd0) begin bad++; $display("FAIL rst_addr: got %0d required 0", sdram_wr_addr); end
        if (fifo_level !== 5'd0) begin bad++; $display("FAIL rst_level: got %0d required 0", fifo_level); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b required 0", overflow); end
        rst_n = 1'b1;
        exp_addr = 0;
    endtask

    task automatic test_ramp();
        do_reset();
        enable = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (adc_clk !== (mdl_cnt < CDIV / 2)) begin
                bad++;
                $display("FAIL ramp_adc_clk: got %b required %b at count %0d", adc_clk, mdl_cnt < CDIV / 2, mdl_cnt);
            end
            @(negedge clk);
        end
        serve_burst(2, 0, "ramp0");
        serve_burst(2, 8, "ramp1");
        serve_burst(2, 16, "ramp2");
        total++;
        if (overflow !== 1'b0) begin bad++; $display("FAIL ramp_overflow: got %b required 0", overflow); end
    endtask

    task automatic test_wrap();
        serve_burst(2, 24, "wrap3");
        serve_burst(2, 32, "wrap4");
    endtask

    task automatic test_overflow();
        int t;
        do_reset();
        enable = 1'b1;
        t = 0;
        while (sdram_wr_req !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (100) @(negedge clk);
        total += 2;
        if (fifo_level !== 5'd16) begin bad++; $display("FAIL ovf_level: got %0d required 16", fifo_level); end
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b required 1", overflow); end
        serve_burst(0, 0, "ovf0");
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
        serve_burst(2, 8, "ovf1");
    endtask

    // Follows test_overflow without reset, so overflow and address are non-zero going in
    task automatic test_rst_midburst();
        int t;
        t = 0;
        while (sdram_wr_req !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        sdram_wr_grant = 1'b1;
        @(negedge clk);
        sdram_wr_grant = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (sdram_wr_en !== 1'b1) begin bad++; $display("FAIL mid_beat3_en: got %b required 1", sdram_wr_en); end
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        total += 5;
        if (sdram_wr_en !== 1'b0) begin bad++; $display("FAIL mid_en: got %b required 0", sdram_wr_en); end
        if (sdram_wr_req !== 1'b0) begin bad++; $display("FAIL mid_req: got %b required 0", sdram_wr_req); end
        if (fifo_level !== 5'd0) begin bad++; $display("FAIL mid_level: got %0d required 0", fifo_level); end
        if (sdram_wr_addr !== 24'd0) begin bad++; $display("FAIL mid_addr: got %0d required 0", sdram_wr_addr); end
        if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow: got %b required 0", overflow); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_addr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (sdram_wr_en !== 1'b0) begin bad++; $display("FAIL mid_post_en: got %b required 0", sdram_wr_en); end
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        wait_samples(12, "edrop");
        enable = 1'b0;
        serve_burst(2, 0, "edrop");
        repeat (3) @(negedge clk);
        total += 2;
        if (fifo_level !== 5'd4) begin bad++; $display("FAIL edrop_level: got %0d required 4", fifo_level); end
        if (sdram_wr_req !== 1'b0) begin bad++; $display("FAIL edrop_req: got %b required 0", sdram_wr_req); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (adc_clk !== 1'b0) begin bad++; $display("FAIL edrop_adc_clk: got %b required 0", adc_clk); end
            @(negedge clk);
        end
    endtask

    task automatic test_idle_grant();
        do_reset();
        enable = 1'b1;
        wait_samples(3, "igrant");
        enable = 1'b0;
        @(negedge clk);
        sdram_wr_grant = 1'b1;
        @(negedge clk);
        sdram_wr_grant = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total += 2;
            if (sdram_wr_en !== 1'b0) begin bad++; $display("FAIL igrant_en: got %b required 0", sdram_wr_en); end
            if (sdram_wr_req !== 1'b0) begin bad++; $display("FAIL igrant_req: got %b required 0", sdram_wr_req); end
            @(negedge clk);
        end
        total++;
        if (fifo_level !== 5'd3) begin bad++; $display("FAIL igrant_level: got %0d required 3", fifo_level); end
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        sdram_wr_grant = 1'b0;
        adc_data = 8'd0;
        test_reset();
        test_ramp();
        test_wrap();
        test_overflow();
        test_rst_midburst();
        test_enable_drop();
        test_idle_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
